// File: rtl/branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_control_unit
// Brief    : EX-stage branch resolver; registers the redirect request and the
//            redirect target. Optional BCU_ALIGN_CHECK_EN adds TARGET_MISALIGNED.
// Revision : 1.0 - initial release
// ============================================================================
module branch_control_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  JUMP,
  input  logic                  BRANCH,
  input  logic [2:0]            FUNC3,
  input  logic [DATA_WIDTH-1:0] OUT1,
  input  logic [DATA_WIDTH-1:0] OUT2,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT,
  output logic [DATA_WIDTH-1:0] TARGET_ADDRESS,
  output logic                  BRANCH_SELECT
`ifdef BCU_ALIGN_CHECK_EN
  ,
  output logic                  TARGET_MISALIGNED
`endif
);

  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;
  localparam logic [2:0] c_F3_BLT  = 3'b100;
  localparam logic [2:0] c_F3_BGE  = 3'b101;
  localparam logic [2:0] c_F3_BLTU = 3'b110;
  localparam logic [2:0] c_F3_BGEU = 3'b111;

  logic                  w_eq;
  logic                  w_lt_s;
  logic                  w_lt_u;
  logic                  w_cond;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_next_target;
  logic                  w_unused_bit0;

  logic [DATA_WIDTH-1:0] r_target_address;
  logic                  r_branch_select;

  assign w_eq   = (OUT1 == OUT2);
  assign w_lt_s = ($signed(OUT1) < $signed(OUT2));
  assign w_lt_u = (OUT1 < OUT2);

  always_comb begin
    w_cond = 1'b0;
    case (FUNC3)
      c_F3_BEQ:  w_cond = w_eq;
      c_F3_BNE:  w_cond = ~w_eq;
      c_F3_BLT:  w_cond = w_lt_s;
      c_F3_BGE:  w_cond = ~w_lt_s;
      c_F3_BLTU: w_cond = w_lt_u;
      c_F3_BGEU: w_cond = ~w_lt_u;
      default:   w_cond = 1'b0;
    endcase
  end

  // A jump overrides the branch condition entirely.
  assign w_taken       = JUMP | (BRANCH & w_cond);
  assign w_next_target = w_taken ? {ALU_RESULT[DATA_WIDTH-1:1], 1'b0} : '0;
  assign w_unused_bit0 = ALU_RESULT[0];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_branch_select  <= 1'b0;
      r_target_address <= '0;
    end else begin
      r_branch_select  <= w_taken;
      r_target_address <= w_next_target;
    end
  end

  assign BRANCH_SELECT  = r_branch_select;
  assign TARGET_ADDRESS = r_target_address;

`ifdef BCU_ALIGN_CHECK_EN
  logic r_target_misaligned;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_target_misaligned <= 1'b0;
    end else begin
      r_target_misaligned <= w_taken & ALU_RESULT[1];
    end
  end

  assign TARGET_MISALIGNED = r_target_misaligned;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_control_unit
// Brief    : Self-checking bench for branch_control_unit (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_control_unit;

  logic        CLK;
  logic        RESETN;
  logic        JUMP;
  logic        BRANCH;
  logic [2:0]  FUNC3;
  logic [31:0] OUT1;
  logic [31:0] OUT2;
  logic [31:0] ALU_RESULT;
  logic [31:0] TARGET_ADDRESS;
  logic        BRANCH_SELECT;
`ifdef BCU_ALIGN_CHECK_EN
  logic        TARGET_MISALIGNED;
`endif

  int checks = 0;
  int errors = 0;

  logic        exp_sel;
  logic [31:0] exp_tgt;
  logic        exp_mis;

  branch_control_unit #(.DATA_WIDTH(32)) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .JUMP           (JUMP),
    .BRANCH         (BRANCH),
    .FUNC3          (FUNC3),
    .OUT1           (OUT1),
    .OUT2           (OUT2),
    .ALU_RESULT     (ALU_RESULT),
    .TARGET_ADDRESS (TARGET_ADDRESS),
    .BRANCH_SELECT  (BRANCH_SELECT)
`ifdef BCU_ALIGN_CHECK_EN
    ,
    .TARGET_MISALIGNED (TARGET_MISALIGNED)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference decision computed straight from the branch rules.
  task automatic model(input logic j, input logic b, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] c, input logic [31:0] alu);
    int signed sa, sc;
    bit cond;
    sa = a;
    sc = c;
    case (f3)
      3'd0: cond = (a == c);
      3'd1: cond = (a != c);
      3'd4: cond = (sa < sc);
      3'd5: cond = (sa >= sc);
      3'd6: cond = (a < c);
      3'd7: cond = (a >= c);
      default: cond = 0;
    endcase
    exp_sel = j || (b && cond);
    exp_tgt = exp_sel ? (alu & 32'hFFFF_FFFE) : 32'h0;
    exp_mis = exp_sel && ((alu % 4) >= 2);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sel"}, {31'b0, BRANCH_SELECT}, {31'b0, exp_sel});
    check({tag, ".tgt"}, TARGET_ADDRESS, exp_tgt);
`ifdef BCU_ALIGN_CHECK_EN
    check({tag, ".mis"}, {31'b0, TARGET_MISALIGNED}, {31'b0, exp_mis});
`endif
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic j, input logic b, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] c, input logic [31:0] alu);
    @(negedge CLK);
    JUMP = j; BRANCH = b; FUNC3 = f3; OUT1 = a; OUT2 = c; ALU_RESULT = alu;
    model(j, b, f3, a, c, alu);
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] a, c;
    JUMP = 0; BRANCH = 0; FUNC3 = 0; OUT1 = 0; OUT2 = 0; ALU_RESULT = 0;
    RESETN = 1'b1;
    #1;
    RESETN = 1'b0;
    #2;
    exp_sel = 0; exp_tgt = 0; exp_mis = 0;
    check_outputs("reset_noclk");
    @(negedge CLK);
    RESETN = 1'b1;

    step("jal",        1, 0, 3'd0, 32'h0,        32'h0, 32'h10);
    step("jal_off",    0, 0, 3'd0, 32'h0,        32'h0, 32'h10);
    step("beq_t",      0, 1, 3'd0, 32'h1,        32'h1, 32'h20);
    step("bne_t",      0, 1, 3'd1, 32'h1,        32'h2, 32'h30);
    step("bne_nt",     0, 1, 3'd1, 32'h5,        32'h5, 32'h30);
    step("blt_t",      0, 1, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h40);
    step("bge_t",      0, 1, 3'd5, 32'h2,        32'h1, 32'h50);
    step("bge_nt",     0, 1, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h50);
    step("bltu_t",     0, 1, 3'd6, 32'h1,        32'h2, 32'h60);
    step("bgeu_t",     0, 1, 3'd7, 32'h2,        32'h1, 32'h70);
    step("bltu_nt",    0, 1, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h60);
    step("f3_010",     0, 1, 3'd2, 32'h1,        32'h1, 32'h90);
    step("f3_011",     0, 1, 3'd3, 32'h1,        32'h2, 32'h90);
    step("jmp_br",     1, 1, 3'd0, 32'h1,        32'h2, 32'h81);
    step("mis_t",      1, 0, 3'd0, 32'h0,        32'h0, 32'h82);
    step("mis_al",     1, 0, 3'd0, 32'h0,        32'h0, 32'h80);
    step("mis_nt",     0, 1, 3'd0, 32'h1,        32'h2, 32'h82);
    step("idle_junk",  0, 0, 3'd0, 32'h7,        32'h7, 32'hABCD);

    // Back-to-back taken redirects with distinct targets.
    step("b2b_0",      1, 0, 3'd0, 32'h0,        32'h0, 32'h100);
    step("b2b_1",      0, 1, 3'd0, 32'h3,        32'h3, 32'h204);

    // Reset pulse between edges while a redirect is being presented.
    step("pre_rst",    1, 0, 3'd0, 32'h0,        32'h0, 32'h3FE);
    RESETN = 1'b0;
    #1;
    exp_sel = 0; exp_tgt = 0; exp_mis = 0;
    check_outputs("mid_rst");
    #1;
    RESETN = 1'b1;
    #1;
    check_outputs("post_rst_hold");
    step("after_rst",  1, 0, 3'd0, 32'h0,        32'h0, 32'h556);

    // Randomized sweep; operands often equal or of mixed sign to hit edges.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: c = a;
        1: c = a ^ 32'h8000_0000;
        2: c = $urandom_range(0, 4);
        default: c = $urandom;
      endcase
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), a, c, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
